// File: rtl/fir_mac_sequencer_if.sv
// ----------------------------------------------------------------------------
// fir_mac_sequencer_if
//   Bundle of the control/status signals between the FIR MAC sequencer and its
//   surroundings: the sample source, the coefficient loader and the datapath
//   (register file + ALU).
//
//   master : the environment side. It drives dr, lc, coefficient_num and
//            overflow, and observes the sequencer outputs.
//   slave  : the sequencer side. It receives the strobes and the ALU overflow
//            flag, and drives the datapath op/addresses and the status flags.
//
//   Signals
//     dr               sample ready (level)
//     lc               load-coefficient strobe (1-cycle pulse)
//     coefficient_num  index of the coefficient on the load bus
//     overflow         ALU overflow for the op issued this cycle
//     cnt_up           sample-accepted pulse
//     clear            coefficient-0-loaded pulse
//     modwait          busy
//     err              error (sequence aborted)
//     op               datapath opcode
//     src1,src2,dest   datapath register addresses
// ----------------------------------------------------------------------------
interface fir_mac_sequencer_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  dr;
  logic                  lc;
  logic [1:0]            coefficient_num;
  logic                  overflow;
  logic                  cnt_up;
  logic                  clear;
  logic                  modwait;
  logic                  err;
  logic [2:0]            op;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic [REG_ADDR_W-1:0] dest;

  modport master (
    output dr, lc, coefficient_num, overflow,
    input  cnt_up, clear, modwait, err, op, src1, src2, dest
  );

  modport slave (
    input  dr, lc, coefficient_num, overflow,
    output cnt_up, clear, modwait, err, op, src1, src2, dest
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// ----------------------------------------------------------------------------
// fir_mac_sequencer
//   Control unit for the FIR datapath. For each accepted sample it issues one
//   datapath op per cycle: shift the sample window (R1..RN), store the new
//   sample into R1, clear the accumulator R0, then NUM_TAPS MUL/ADD pairs that
//   accumulate sample*coefficient into R0. Coefficient-load strobes write the
//   next coefficient register in order 0..NUM_TAPS-1. An ALU overflow during
//   the MAC passes, or a sample-ready level that drops before it is confirmed,
//   aborts into an error-idle state.
//
//   Register map: R0 accumulator, R1..RN samples (R1 newest),
//                 R(N+1+k) coefficient k, R(2N+1) product temporary.
//
//   Ports
//     clk      in   clock, all state on rising edge
//     n_reset  in   asynchronous active-low reset
//     bus      slave side of fir_mac_sequencer_if (strobes in, op/flags out)
//
//   All outputs are registered and depend only on state and counters.
// ----------------------------------------------------------------------------
module fir_mac_sequencer #(
  parameter int NUM_TAPS   = 4,
  parameter int REG_ADDR_W = 4
) (
  input logic                clk,
  input logic                n_reset,
  fir_mac_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_TAPS);

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_COPY       = 3'd1;
  localparam logic [2:0] OP_LOAD_SAMPLE = 3'd2;
  localparam logic [2:0] OP_LOAD_COEFF = 3'd3;
  localparam logic [2:0] OP_ADD        = 3'd4;
  localparam logic [2:0] OP_SUB        = 3'd5;
  localparam logic [2:0] OP_MUL        = 3'd6;

  localparam logic [REG_ADDR_W-1:0] ADDR_ACC    = '0;
  localparam logic [REG_ADDR_W-1:0] ADDR_NEWEST = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] ADDR_COEF0  = REG_ADDR_W'(NUM_TAPS + 1);
  localparam logic [REG_ADDR_W-1:0] ADDR_TMP    = REG_ADDR_W'(2 * NUM_TAPS + 1);

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDCOEF,
    S_CAPTURE,
    S_SHIFT,
    S_STORE,
    S_ZERO,
    S_MUL,
    S_ACC,
    S_EIDLE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] j_reg, j_next;       // shift counter: source sample index
  logic [CNT_W-1:0] k_reg, k_next;       // tap counter
  logic [CNT_W-1:0] cidx_reg, cidx_next; // next coefficient slot to load

  logic                  cnt_up_reg, cnt_up_next;
  logic                  clear_reg, clear_next;
  logic                  modwait_reg, modwait_next;
  logic                  err_reg, err_next;
  logic [2:0]            op_reg, op_next;
  logic [REG_ADDR_W-1:0] src1_reg, src1_next;
  logic [REG_ADDR_W-1:0] src2_reg, src2_next;
  logic [REG_ADDR_W-1:0] dest_reg, dest_next;

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    cidx_next  = cidx_reg;

    unique case (state_reg)
      S_IDLE, S_EIDLE: begin
        // A coefficient load wins over a sample; a sample still pending after
        // the load is picked up on the return to IDLE.
        if (bus.lc) begin
          state_next = S_LDCOEF;
        end else if (bus.dr) begin
          state_next = S_CAPTURE;
        end
      end

      S_LDCOEF: begin
        state_next = S_IDLE;
        cidx_next  = (cidx_reg == LAST_TAP) ? '0 : cidx_reg + CNT_ONE;
      end

      S_CAPTURE: begin
        // dr must still be high one cycle after it was seen; otherwise the
        // source glitched and no datapath state is touched.
        if (!bus.dr) begin
          state_next = S_EIDLE;
        end else begin
          state_next = S_SHIFT;
          j_next     = LAST_TAP;
        end
      end

      S_SHIFT: begin
        // Copy from the oldest end downwards so no sample is overwritten
        // before it has been moved.
        if (j_reg == CNT_ONE) begin
          state_next = S_STORE;
        end else begin
          j_next = j_reg - CNT_ONE;
        end
      end

      S_STORE: begin
        state_next = S_ZERO;
      end

      S_ZERO: begin
        state_next = S_MUL;
        k_next     = '0;
      end

      S_MUL: begin
        state_next = bus.overflow ? S_EIDLE : S_ACC;
      end

      S_ACC: begin
        if (bus.overflow) begin
          state_next = S_EIDLE;
        end else if (k_reg == LAST_TAP) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_MUL;
          k_next     = k_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode for the state being entered, so the registered outputs line
  // up with the registered state.
  // --------------------------------------------------------------------------
  always_comb begin
    op_next      = OP_NOP;
    src1_next    = '0;
    src2_next    = '0;
    dest_next    = '0;
    cnt_up_next  = 1'b0;
    clear_next   = 1'b0;
    modwait_next = 1'b1;
    err_next     = 1'b0;

    unique case (state_next)
      S_IDLE: begin
        modwait_next = 1'b0;
      end

      S_EIDLE: begin
        modwait_next = 1'b0;
        err_next     = 1'b1;
      end

      S_LDCOEF: begin
        op_next    = OP_LOAD_COEFF;
        dest_next  = ADDR_COEF0 + REG_ADDR_W'(cidx_next);
        clear_next = (cidx_next == '0);
      end

      S_CAPTURE: begin
        op_next = OP_NOP;
      end

      S_SHIFT: begin
        op_next   = OP_COPY;
        src1_next = REG_ADDR_W'(j_next);
        dest_next = REG_ADDR_W'(j_next) + REG_ADDR_W'(1);
      end

      S_STORE: begin
        op_next     = OP_LOAD_SAMPLE;
        dest_next   = ADDR_NEWEST;
        cnt_up_next = 1'b1;
      end

      S_ZERO: begin
        // R0 - R0 clears the accumulator without needing a constant register.
        op_next   = OP_SUB;
        src1_next = ADDR_ACC;
        src2_next = ADDR_ACC;
        dest_next = ADDR_ACC;
      end

      S_MUL: begin
        op_next   = OP_MUL;
        src1_next = ADDR_NEWEST + REG_ADDR_W'(k_next);
        src2_next = ADDR_COEF0 + REG_ADDR_W'(k_next);
        dest_next = ADDR_TMP;
      end

      S_ACC: begin
        op_next   = OP_ADD;
        src1_next = ADDR_ACC;
        src2_next = ADDR_TMP;
        dest_next = ADDR_ACC;
      end

      default: begin
        modwait_next = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg   <= S_IDLE;
      j_reg       <= '0;
      k_reg       <= '0;
      cidx_reg    <= '0;
      op_reg      <= OP_NOP;
      src1_reg    <= '0;
      src2_reg    <= '0;
      dest_reg    <= '0;
      cnt_up_reg  <= 1'b0;
      clear_reg   <= 1'b0;
      modwait_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      j_reg       <= j_next;
      k_reg       <= k_next;
      cidx_reg    <= cidx_next;
      op_reg      <= op_next;
      src1_reg    <= src1_next;
      src2_reg    <= src2_next;
      dest_reg    <= dest_next;
      cnt_up_reg  <= cnt_up_next;
      clear_reg   <= clear_next;
      modwait_reg <= modwait_next;
      err_reg     <= err_next;
    end
  end

  assign bus.op      = op_reg;
  assign bus.src1    = src1_reg;
  assign bus.src2    = src2_reg;
  assign bus.dest    = dest_reg;
  assign bus.cnt_up  = cnt_up_reg;
  assign bus.clear   = clear_reg;
  assign bus.modwait = modwait_reg;
  assign bus.err     = err_reg;

  // The loader numbers coefficients itself; the internal index is what
  // addresses the register file, so the two must never drift apart.
  logic lc_accepted;
  assign lc_accepted = bus.lc && ((state_reg == S_IDLE) || (state_reg == S_EIDLE));

  coeff_order_check : assert property (
    @(posedge clk) disable iff (!n_reset)
    lc_accepted |-> (int'(bus.coefficient_num) == int'(cidx_reg))
  );

endmodule
